// File: rtl/mac_pkg.sv
// Shared MAC constants and framer state encoding.
// Used by the TX framer and the RX parser.
package mac_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
    localparam int          HDR_BYTES     = 14;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        HDR,
        PAY,
        PAD,
        FCS,
        IFG
    } state_t;

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 step, LSB of data first.
// No init or final inversion; the caller owns both.
module crc32_d8
    import mac_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_upd
);

    always_comb begin
        crc_upd = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_upd[0] ^ data[i])
                crc_upd = (crc_upd >> 1) ^ CRC_POLY;
            else
                crc_upd = crc_upd >> 1;
        end
    end

endmodule

// File: rtl/mac_tx_frame.sv
// Ethernet II transmit framer: preamble, header, payload,
// pad, FCS and inter-frame gap as a registered byte stream.
module mac_tx_frame
    import mac_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_01_02_03,
    parameter int          IFG_BYTES   = 12,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_start,
    input  logic [10:0] tx_len,
    input  logic [47:0] dst_mac,
    input  logic [15:0] eth_type,
    input  logic [7:0]  tx_data,
    output logic        tx_data_rd,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        mac_txdv,
    output logic [7:0]  mac_txd
);

    state_t       state;
    logic [10:0]  cnt;
    logic [10:0]  eff_len;
    logic [111:0] hdr_q;
    logic [31:0]  crc;
    logic [31:0]  crc_upd;
    logic [31:0]  fcs_inv;
    logic [7:0]   cur_byte;
    logic [6:0]   hdr_idx;
    logic [4:0]   fcs_idx;
    logic [5:0]   pad_cnt;
    logic         crc_en;
    logic         ifg_last;
    logic         start_ok;

    assign tx_data_rd = (state == PAY);
    assign crc_en     = state inside {HDR, PAY, PAD};
    assign pad_cnt    = 6'(MIN_PAYLOAD) - eff_len[5:0];
    assign hdr_idx    = 7'd111 - {cnt[3:0], 3'b000};
    assign fcs_idx    = {cnt[1:0], 3'b000};
    assign fcs_inv    = ~crc;
    assign ifg_last   = (state == IFG) &&
                        (cnt == 11'(IFG_BYTES - 1));
    // A request is also taken on the last IFG cycle so
    // back-to-back frames keep exactly IFG_BYTES of gap.
    assign start_ok   = tx_start &&
                        ((state == IDLE) || ifg_last);

    always_comb begin
        cur_byte = 8'h00;
        unique case (state)
            PRE:     cur_byte = PREAMBLE_BYTE;
            SFD:     cur_byte = SFD_BYTE;
            HDR:     cur_byte = hdr_q[hdr_idx -: 8];
            PAY:     cur_byte = tx_data;
            FCS:     cur_byte = fcs_inv[fcs_idx +: 8];
            default: cur_byte = 8'h00;
        endcase
    end

    crc32_d8 u_crc (
        .crc     (crc),
        .data    (cur_byte),
        .crc_upd (crc_upd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            eff_len  <= '0;
            hdr_q    <= '0;
            crc      <= CRC_INIT;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            mac_txdv <= 1'b0;
            mac_txd  <= 8'h00;
        end else begin
            mac_txdv <= state inside {PRE, SFD, HDR,
                                      PAY, PAD, FCS};
            mac_txd  <= cur_byte;
            cnt      <= cnt + 11'd1;
            tx_done  <= 1'b0;
            if (crc_en)
                crc <= crc_upd;

            unique case (state)
                IDLE: cnt <= '0;
                PRE: begin
                    if (cnt == 11'd6) begin
                        state <= SFD;
                        cnt   <= '0;
                    end
                end
                SFD: begin
                    state <= HDR;
                    cnt   <= '0;
                end
                HDR: begin
                    if (cnt == 11'(HDR_BYTES - 1)) begin
                        cnt   <= '0;
                        state <= (eff_len == '0) ? PAD : PAY;
                    end
                end
                PAY: begin
                    if (cnt == eff_len - 11'd1) begin
                        cnt   <= '0;
                        state <= (eff_len < 11'(MIN_PAYLOAD))
                                 ? PAD : FCS;
                    end
                end
                PAD: begin
                    if (cnt[5:0] == pad_cnt - 6'd1) begin
                        cnt   <= '0;
                        state <= FCS;
                    end
                end
                FCS: begin
                    if (cnt == 11'd3) begin
                        cnt     <= '0;
                        state   <= IFG;
                        tx_done <= (IFG_BYTES == 1);
                    end
                end
                IFG: begin
                    if (ifg_last) begin
                        cnt     <= '0;
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end else begin
                        tx_done <= (cnt + 11'd2 ==
                                    11'(IFG_BYTES));
                    end
                end
                default: state <= IDLE;
            endcase

            if (start_ok) begin
                state   <= PRE;
                cnt     <= '0;
                tx_busy <= 1'b1;
                crc     <= CRC_INIT;
                hdr_q   <= {dst_mac, LOCAL_MAC, eth_type};
                eff_len <= (tx_len > 11'(MAX_PAYLOAD))
                           ? 11'(MAX_PAYLOAD) : tx_len;
            end
        end
    end

endmodule

// File: tb/tb_mac_tx_frame.sv
// Scoreboard bench for mac_tx_frame: expected bytes are
// queued at request time and popped as the DUT emits them.
module tb_mac_tx_frame;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_start;
    logic [10:0] tx_len;
    logic [47:0] dst_mac;
    logic [15:0] eth_type;
    logic [7:0]  tx_data;
    logic        tx_data_rd;
    logic        tx_busy;
    logic        tx_done;
    logic        mac_txdv;
    logic [7:0]  mac_txd;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    int         len_q[$];

    int rd_cnt   = 0;
    int rd_base  = 0;
    int pay_seed = 0;

    int          run_len  = 0;
    int          gap      = 0;
    int          last_gap = 0;
    int          rise_cnt = 0;
    int          done_cnt = 0;
    logic        abort    = 1'b0;
    logic [31:0] res      = 32'hFFFFFFFF;

    mac_tx_frame dut (
        .clk        (clk),
        .rst        (rst),
        .tx_start   (tx_start),
        .tx_len     (tx_len),
        .dst_mac    (dst_mac),
        .eth_type   (eth_type),
        .tx_data    (tx_data),
        .tx_data_rd (tx_data_rd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .mac_txdv   (mac_txdv),
        .mac_txd    (mac_txd)
    );

    always #4 clk = ~clk;

    // FWFT payload source: byte k of a frame is seed + k
    assign tx_data = 8'(pay_seed + rd_cnt - rd_base);

    always @(posedge clk)
        if (tx_data_rd)
            rd_cnt <= rd_cnt + 1;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(
        input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic push_frame(input logic [10:0] len,
                              input logic [47:0] dst,
                              input logic [15:0] et,
                              input int seed);
        int          eff;
        logic [31:0] c;
        logic [7:0]  b;
        logic [111:0] hdr;
        eff = (len > 1500) ? 1500 : int'(len);
        hdr = {dst, 48'h000A35010203, et};
        c   = 32'hFFFFFFFF;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < 14; i++) begin
            b = hdr[111 - 8*i -: 8];
            exp_q.push_back(b);
            c = crc_step(c, b);
        end
        for (int k = 0; k < eff; k++) begin
            b = 8'(seed + k);
            exp_q.push_back(b);
            c = crc_step(c, b);
        end
        for (int k = eff; k < 46; k++) begin
            exp_q.push_back(8'h00);
            c = crc_step(c, 8'h00);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(c[7:0]);
            c = c >> 8;
        end
        len_q.push_back(8 + 14 + ((eff < 46) ? 46 : eff) + 4);
    endtask

    task automatic start_frame(input logic [10:0] len,
                               input logic [47:0] dst,
                               input logic [15:0] et,
                               input int seed);
        pay_seed = seed;
        rd_base  = rd_cnt;
        tx_len   = len;
        dst_mac  = dst;
        eth_type = et;
        tx_start = 1'b1;
        push_frame(len, dst, et, seed);
        @(negedge clk);
        tx_start = 1'b0;
        chk("busy_rise", {31'b0, tx_busy}, 32'd1);
        chk("txdv_early", {31'b0, mac_txdv}, 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((tx_busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'b0, n < budget}, 32'd1);
    endtask

    task automatic out_zero(input string tag);
        chk({tag, "_txdv"}, {31'b0, mac_txdv}, 32'd0);
        chk({tag, "_txd"}, {24'b0, mac_txd}, 32'd0);
        chk({tag, "_rd"}, {31'b0, tx_data_rd}, 32'd0);
        chk({tag, "_busy"}, {31'b0, tx_busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, tx_done}, 32'd0);
    endtask

    // Output monitor: byte values, frame length, CRC residue, gaps
    always @(negedge clk) begin
        if (mac_txdv) begin
            if (run_len == 0) begin
                last_gap = gap;
                rise_cnt++;
            end
            run_len++;
            gap = 0;
            if (run_len > 8)
                res = crc_step(res, mac_txd);
            if (exp_q.size() == 0)
                chk("extra_byte", exp_q.size(), 32'd1);
            else
                chk("txd", {24'b0, mac_txd}, {24'b0, exp_q.pop_front()});
        end else begin
            if (run_len != 0 && !abort) begin
                if (len_q.size() == 0)
                    chk("len_q_empty", len_q.size(), 32'd1);
                else
                    chk("frame_len", run_len, len_q.pop_front());
                chk("residue", res, 32'hDEBB20E3);
            end
            if (run_len != 0) begin
                run_len = 0;
                res     = 32'hFFFFFFFF;
            end
            gap++;
        end
        if (tx_done)
            done_cnt++;
    end

    initial begin
        int d0;
        int r0;
        int n;
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_len   = '0;
        dst_mac  = '0;
        eth_type = '0;
        repeat (3) @(negedge clk);
        out_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Minimum frame with ARP-style header
        d0 = done_cnt;
        start_frame(11'd46, 48'hFFFFFFFFFFFF, 16'h0806, 0);
        wait_idle(300);
        chk("rd_46", rd_cnt - rd_base, 32'd46);
        chk("done_46", done_cnt - d0, 32'd1);

        // Empty payload: all pad
        start_frame(11'd0, 48'h112233445566, 16'h0800, 9);
        wait_idle(300);
        chk("rd_0", rd_cnt - rd_base, 32'd0);

        // Oversize request is clamped
        start_frame(11'd2000, 48'h0A0B0C0D0E0F, 16'h86DD, 3);
        wait_idle(2000);
        chk("rd_2000", rd_cnt - rd_base, 32'd1500);

        // Back-to-back with tx_start held and fields wiggled while busy
        @(negedge clk);
        pay_seed = 100;
        rd_base  = rd_cnt;
        tx_len   = 11'd60;
        dst_mac  = 48'h020000ABCDEF;
        eth_type = 16'h88B5;
        tx_start = 1'b1;
        push_frame(11'd60, 48'h020000ABCDEF, 16'h88B5, 100);
        push_frame(11'd60, 48'h020000ABCDEF, 16'h88B5, 160);
        d0 = done_cnt;
        r0 = rise_cnt;
        repeat (30) @(negedge clk);
        tx_len  = 11'd5;
        dst_mac = 48'h0;
        repeat (5) @(negedge clk);
        tx_len  = 11'd60;
        dst_mac = 48'h020000ABCDEF;
        n = 0;
        while (!tx_done && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", {31'b0, tx_done}, 32'd1);
        @(negedge clk);
        tx_start = 1'b0;
        wait_idle(400);
        chk("b2b_done_pulses", done_cnt - d0, 32'd2);
        chk("b2b_frames", rise_cnt - r0, 32'd2);
        chk("b2b_gap", last_gap, 32'd12);
        chk("b2b_rd", rd_cnt - rd_base, 32'd120);

        // Reset in the middle of the payload
        start_frame(11'd60, 48'h5A5A5A5A5A5A, 16'h0800, 7);
        n = 0;
        while (rd_cnt - rd_base != 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_pay10", rd_cnt - rd_base, 32'd10);
        #2;
        abort = 1'b1;
        rst   = 1'b1;
        #1;
        out_zero("midrst");
        exp_q.delete();
        len_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_txdv", {31'b0, mac_txdv}, 32'd0);
        abort = 1'b0;
        start_frame(11'd50, 48'h00112233AABB, 16'h0800, 200);
        wait_idle(300);
        chk("rd_after_rst", rd_cnt - rd_base, 32'd50);
        chk("q_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
